// File: rtl/rx_comma_aligner.sv
// Serial 10b receiver: shifts bits in LSB-first, locks on K28.5 and frames symbols.
// Define RX_ALIGN_LOSS_EN to drop lock after LOSS_COUNT misaligned commas.
module rx_comma_aligner #(
    parameter int DATA_WIDTH = 10,
    parameter int LOSS_COUNT = 3
) (
    input  logic                  Bit_Rate_Clk,
    input  logic                  Rst_n,
    input  logic                  RX_In_P,
    input  logic                  Align_En,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Data_Valid,
    output logic                  Comma_Det,
    output logic                  Aligned
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] K28_5_N = DATA_WIDTH'(10'h17C);
    localparam logic [DATA_WIDTH-1:0] K28_5_P = DATA_WIDTH'(10'h283);

    typedef enum logic {
        UNALIGNED,
        ALIGNED
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] next_sr;
    logic [DATA_WIDTH-1:0] dout_nx;
    logic [CW-1:0]         bit_cnt;
    logic [CW-1:0]         cnt_nx;
    logic                  dv_nx;
    logic                  cd_nx;
    logic                  is_comma;

`ifdef RX_ALIGN_LOSS_EN
    localparam int MW = $clog2(LOSS_COUNT + 1);
    logic [MW-1:0] mis;
    logic [MW-1:0] mis_nx;
`else
    localparam int loss_count_unused = LOSS_COUNT;
`endif

    assign next_sr  = {RX_In_P, sr[DATA_WIDTH-1:1]};
    assign is_comma = (next_sr == K28_5_N) || (next_sr == K28_5_P);
    assign Aligned  = (state == ALIGNED);

    always_comb begin
        state_nx = state;
        cnt_nx   = bit_cnt;
        dout_nx  = Data_out;
        dv_nx    = 1'b0;
        cd_nx    = 1'b0;
`ifdef RX_ALIGN_LOSS_EN
        mis_nx   = mis;
`endif
        if (!Align_En) begin
            state_nx = UNALIGNED;
            cnt_nx   = '0;
`ifdef RX_ALIGN_LOSS_EN
            mis_nx   = '0;
`endif
        end else begin
            unique case (state)
                UNALIGNED: begin
                    if (is_comma) begin
                        state_nx = ALIGNED;
                        cnt_nx   = '0;
                        dout_nx  = next_sr;
                        dv_nx    = 1'b1;
                        cd_nx    = 1'b1;
                    end
                end
                ALIGNED: begin
                    if (bit_cnt == LAST) begin
                        cnt_nx  = '0;
                        dout_nx = next_sr;
                        dv_nx   = 1'b1;
                        cd_nx   = is_comma;
`ifdef RX_ALIGN_LOSS_EN
                        if (is_comma) mis_nx = '0;
`endif
                    end else begin
                        cnt_nx = bit_cnt + 1'b1;
`ifdef RX_ALIGN_LOSS_EN
                        // A comma off the symbol grid counts toward loss of lock
                        if (is_comma) begin
                            if (mis == MW'(LOSS_COUNT - 1)) begin
                                state_nx = UNALIGNED;
                                cnt_nx   = '0;
                                mis_nx   = '0;
                            end else begin
                                mis_nx = mis + 1'b1;
                            end
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Bit_Rate_Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= UNALIGNED;
            sr         <= '0;
            bit_cnt    <= '0;
            Data_out   <= '0;
            Data_Valid <= 1'b0;
            Comma_Det  <= 1'b0;
        end else begin
            state      <= state_nx;
            sr         <= next_sr;
            bit_cnt    <= cnt_nx;
            Data_out   <= dout_nx;
            Data_Valid <= dv_nx;
            Comma_Det  <= cd_nx;
        end
    end

`ifdef RX_ALIGN_LOSS_EN
    always_ff @(posedge Bit_Rate_Clk or negedge Rst_n) begin
        if (!Rst_n) mis <= '0;
        else        mis <= mis_nx;
    end
`endif

endmodule

// File: tb/tb_rx_comma_aligner.sv
// Randomized bench for rx_comma_aligner against a bit-stream reference model.
// Honours RX_ALIGN_LOSS_EN the same way the design does.
module tb_rx_comma_aligner;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       align_en;
    logic [9:0] data_out;
    logic       data_valid;
    logic       comma_det;
    logic       aligned;

    int n_chk;
    int n_err;

    // reference model state
    logic [9:0] m_win;
    logic [9:0] m_dout;
    bit         m_al;
    bit         m_dv;
    bit         m_cd;
    int         m_since;
    int         m_mis;
    bit         loss_en;
    int         exp_loss_al;

    localparam int LOSS = 3;

    rx_comma_aligner #(
        .DATA_WIDTH(10),
        .LOSS_COUNT(LOSS)
    ) dut (
        .Bit_Rate_Clk(clk),
        .Rst_n       (rst_n),
        .RX_In_P     (rx),
        .Align_En    (align_en),
        .Data_out    (data_out),
        .Data_Valid  (data_valid),
        .Comma_Det   (comma_det),
        .Aligned     (aligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_k28(input logic [9:0] w);
        return (w == 10'h17C) || (w == 10'h283);
    endfunction

    task automatic model_reset();
        m_win   = '0;
        m_dout  = '0;
        m_al    = 0;
        m_dv    = 0;
        m_cd    = 0;
        m_since = 0;
        m_mis   = 0;
    endtask

    // Last ten received bits form the window; once locked, every tenth bit
    // after the locking comma closes a symbol.
    task automatic model_step(input logic b, input logic en);
        bit c;
        m_win = {b, m_win[9:1]};
        c     = is_k28(m_win);
        m_dv  = 0;
        m_cd  = 0;
        if (!en) begin
            m_al    = 0;
            m_since = 0;
            m_mis   = 0;
        end else if (!m_al) begin
            if (c) begin
                m_al    = 1;
                m_since = 0;
                m_dv    = 1;
                m_cd    = 1;
                m_dout  = m_win;
            end
        end else begin
            m_since++;
            if (m_since % 10 == 0) begin
                m_dv   = 1;
                m_cd   = c;
                m_dout = m_win;
                if (c) m_mis = 0;
            end else if (loss_en && c) begin
                m_mis++;
                if (m_mis >= LOSS) begin
                    m_al  = 0;
                    m_mis = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        check("dv",   32'(data_valid), 32'(m_dv));
        check("cd",   32'(comma_det),  32'(m_cd));
        check("al",   32'(aligned),    32'(m_al));
        check("dout", 32'(data_out),   32'(m_dout));
    endtask

    task automatic tick(input logic b);
        rx = b;
        @(posedge clk);
        model_step(b, align_en);
        #1;
        check_all();
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) tick(s[i]);
    endtask

    task automatic pad(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_al", 32'(aligned), 32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic bit prefix_ok(input logic [6:0] p);
        logic [16:0] s;
        logic [9:0]  w;
        s = {10'h17C, p};
        w = '0;
        for (int i = 0; i < 16; i++) begin
            w = {s[i], w[9:1]};
            if (is_k28(w)) return 0;
        end
        return 1;
    endfunction

    initial begin
        logic [6:0] pre;
        int         sel;
        n_chk    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        rx       = 1'b0;
        align_en = 1'b0;
`ifdef RX_ALIGN_LOSS_EN
        loss_en     = 1;
        exp_loss_al = 0;
`else
        loss_en     = 0;
        exp_loss_al = 1;
`endif
        model_reset();
        @(posedge clk);
        #1;
        pulse_reset();

        // lock after 7 random bits: 17th edge
        align_en = 1'b1;
        pre = 7'($urandom);
        while (!prefix_ok(pre)) pre = 7'($urandom);
        for (int i = 0; i < 7; i++) tick(pre[i]);
        send_sym(10'h17C);
        check("lock_dv",   32'(data_valid), 32'd1);
        check("lock_cd",   32'(comma_det),  32'd1);
        check("lock_al",   32'(aligned),    32'd1);
        check("lock_dout", 32'(data_out),   32'h17C);

        send_sym(10'h283);
        check("s283_dv", 32'(data_valid), 32'd1);
        check("s283_d",  32'(data_out),   32'h283);
        check("s283_cd", 32'(comma_det),  32'd1);
        send_sym(10'h0F3);
        check("s0f3_dv", 32'(data_valid), 32'd1);
        check("s0f3_d",  32'(data_out),   32'h0F3);
        check("s0f3_cd", 32'(comma_det),  32'd0);

        // alignment disabled
        align_en = 1'b0;
        send_sym(10'h17C);
        check("dis_dv", 32'(data_valid), 32'd0);
        send_sym(10'h17C);
        check("dis_al", 32'(aligned), 32'd0);
        align_en = 1'b1;
        send_sym(10'h17C);
        check("en_al", 32'(aligned),    32'd1);
        check("en_dv", 32'(data_valid), 32'd1);

        // reset mid-symbol
        for (int i = 0; i < 4; i++) tick(1'($urandom));
        pulse_reset();
        check("rst_dv",   32'(data_valid), 32'd0);
        check("rst_dout", 32'(data_out),   32'd0);
        send_sym(10'h17C);
        check("relock_al", 32'(aligned),  32'd1);
        check("relock_d",  32'(data_out), 32'h17C);

        // three commas off the grid by 3 bits each
        for (int k = 0; k < 3; k++) begin
            pad(3);
            send_sym(10'h17C);
        end
        check("loss_al", 32'(aligned), 32'(exp_loss_al));

        // misaligned x2, aligned, misaligned x2
        pulse_reset();
        send_sym(10'h17C);
        pad(3); send_sym(10'h17C);
        pad(3); send_sym(10'h17C);
        pad(4); send_sym(10'h283);
        check("grid_dv", 32'(data_valid), 32'd1);
        check("grid_cd", 32'(comma_det),  32'd1);
        pad(3); send_sym(10'h17C);
        pad(3); send_sym(10'h17C);
        check("keep_al", 32'(aligned), 32'd1);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            align_en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 49) == 0) pulse_reset();
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                send_sym(10'($urandom));
            end else if (sel < 7) begin
                send_sym($urandom_range(0, 1) ? 10'h17C : 10'h283);
            end else begin
                for (int i = 0; i < $urandom_range(1, 9); i++) tick(1'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
